// File: rtl/target_pin_arbiter_pkg.sv
// Shared definitions for the target pin arbiter: requester indices, FSM
// state encoding, pin bundle type and the priority encoder.
package target_pin_arbiter_pkg;

  localparam int REQ_AVR  = 0;
  localparam int REQ_PDI  = 1;
  localparam int REQ_GPIO = 2;
  localparam int NREQ     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // One bit per target pin, used for both value and output-enable bundles.
  typedef struct packed {
    logic nrst;
    logic mosi;
    logic sck;
    logic pdid;
    logic pdic;
  } pins_t;

  // Isolates the lowest set bit, so requester 0 has the highest priority.
  function automatic logic [NREQ-1:0] priority_onehot(input logic [NREQ-1:0] r);
    return r & (~r + NREQ'(1));
  endfunction

endpackage

// File: rtl/target_pin_arbiter_if.sv
// Arbitration handshake between the requesters and the pin arbiter.
interface target_pin_arbiter_if;
  import target_pin_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic            target_highz;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            abort_o;

  modport master (
    output req,
    output target_highz,
    input  grant,
    input  busy,
    input  abort_o
  );

  modport slave (
    input  req,
    input  target_highz,
    output grant,
    output busy,
    output abort_o
  );

endinterface

// File: rtl/target_pin_arbiter.sv
// Non-preemptive fixed-priority owner arbitration for the shared target
// programming pins, with a float guard interval on every hand-off and a
// registered pin mux driving the top-level tri-state pads.
module target_pin_arbiter
  import target_pin_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned CNT_W        = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  target_pin_arbiter_if.slave  bus,
  input  logic                 avr_nrst_i,
  input  logic                 avr_mosi_i,
  input  logic                 avr_sck_i,
  input  logic                 pdi_d_i,
  input  logic                 pdi_d_oe_i,
  input  logic                 pdi_c_i,
  input  logic                 gpio_nrst_i,
  input  logic                 gpio_nrst_oe_i,
  output logic                 nrst_o,
  output logic                 nrst_oe,
  output logic                 mosi_o,
  output logic                 mosi_oe,
  output logic                 sck_o,
  output logic                 sck_oe,
  output logic                 pdid_o,
  output logic                 pdid_oe,
  output logic                 pdic_o,
  output logic                 pdic_oe
);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d;
  pins_t           pin_o_q, pin_o_d;
  pins_t           pin_oe_q, pin_oe_d;

  // Next-state logic: grant holds the owner as one-hot, release clears it.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.target_highz && (|bus.req)) begin
          grant_d = priority_onehot(bus.req);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.target_highz || !(|(bus.req & grant_q))) begin
          abort_d = bus.target_highz;
          grant_d = '0;
          if (GUARD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            cnt_d   = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
          end
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Pin mux keyed on the next owner so drive starts on the grant edge and
  // stops on the release edge; a value is forced low whenever its enable is.
  always_comb begin
    pin_o_d  = '0;
    pin_oe_d = '0;
    if (grant_d[REQ_AVR]) begin
      pin_o_d.nrst  = avr_nrst_i;
      pin_o_d.mosi  = avr_mosi_i;
      pin_o_d.sck   = avr_sck_i;
      pin_oe_d.nrst = 1'b1;
      pin_oe_d.mosi = 1'b1;
      pin_oe_d.sck  = 1'b1;
    end else if (grant_d[REQ_PDI]) begin
      pin_o_d.pdid  = pdi_d_i & pdi_d_oe_i;
      pin_oe_d.pdid = pdi_d_oe_i;
      pin_o_d.pdic  = pdi_c_i;
      pin_oe_d.pdic = 1'b1;
    end else if (grant_d[REQ_GPIO]) begin
      pin_o_d.nrst  = gpio_nrst_i & gpio_nrst_oe_i;
      pin_oe_d.nrst = gpio_nrst_oe_i;
    end
  end

  // State and registered pin drive; reset floats every pin immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      pin_o_q  <= '0;
      pin_oe_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      pin_o_q  <= pin_o_d;
      pin_oe_q <= pin_oe_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.abort_o = abort_q;

  assign nrst_o  = pin_o_q.nrst;
  assign nrst_oe = pin_oe_q.nrst;
  assign mosi_o  = pin_o_q.mosi;
  assign mosi_oe = pin_oe_q.mosi;
  assign sck_o   = pin_o_q.sck;
  assign sck_oe  = pin_oe_q.sck;
  assign pdid_o  = pin_o_q.pdid;
  assign pdid_oe = pin_oe_q.pdid;
  assign pdic_o  = pin_o_q.pdic;
  assign pdic_oe = pin_oe_q.pdic;

endmodule
